// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: state codes, instruction
// op/cmd fields, ALU control codes, condition codes, the control-output
// bundle and the condition evaluator used when MC_CTRL_COND_EN is defined.
package mc_ctrl_pkg;

  // FSM state codes. FETCH is 0 so the reset value and the all-zero output
  // image during reset agree.
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADDR  = 4'd2;
  localparam logic [3:0] S_EXEC_R   = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_BRANCH   = 4'd5;
  localparam logic [3:0] S_MEMREAD  = 4'd6;
  localparam logic [3:0] S_MEMWRITE = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_MEMWB    = 4'd9;
  localparam logic [3:0] S_FAULT    = 4'd10;

  // Instruction classes.
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  // Data-processing commands (funct[4:1]).
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_RSB = 4'b0011;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ADC = 4'b0101;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_TEQ = 4'b1001;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // ALU control codes.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_ADC = 3'b100;
  localparam logic [2:0] ALU_RSB = 3'b101;
  localparam logic [2:0] ALU_EOR = 3'b111;

  // Condition codes.
  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_MI = 4'b0100;
  localparam logic [3:0] CC_PL = 4'b0101;
  localparam logic [3:0] CC_VS = 4'b0110;
  localparam logic [3:0] CC_VC = 4'b0111;
  localparam logic [3:0] CC_HI = 4'b1000;
  localparam logic [3:0] CC_LS = 4'b1001;
  localparam logic [3:0] CC_GE = 4'b1010;
  localparam logic [3:0] CC_LT = 4'b1011;
  localparam logic [3:0] CC_GT = 4'b1100;
  localparam logic [3:0] CC_LE = 4'b1101;
  localparam logic [3:0] CC_AL = 4'b1110;

  // Every control output except alu_control width and state_o.
  typedef struct packed {
    logic       mem_req;
    logic       mem_w;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_w;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] alu_ctl;
    logic [1:0] flag_w;
    logic       fault;
  } ctrl_t;

  // Condition check against NZCV; 1111 never passes.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cond)
      CC_EQ:   cond_pass = z;
      CC_NE:   cond_pass = !z;
      CC_CS:   cond_pass = c;
      CC_CC:   cond_pass = !c;
      CC_MI:   cond_pass = n;
      CC_PL:   cond_pass = !n;
      CC_VS:   cond_pass = v;
      CC_VC:   cond_pass = !v;
      CC_HI:   cond_pass = c & !z;
      CC_LS:   cond_pass = !c | z;
      CC_GE:   cond_pass = (n == v);
      CC_LT:   cond_pass = (n != v);
      CC_GT:   cond_pass = !z & (n == v);
      CC_LE:   cond_pass = z | (n != v);
      CC_AL:   cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational data-processing decode: cmd -> ALU control code, legality,
// "no register write" (compare/test class) and flag-write enables.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] cmd,
  input  logic       s_bit,
  output logic [2:0] alu_ctl,
  output logic       legal,
  output logic       no_write,
  output logic [1:0] flag_w
);

  logic s_eff;

  // Map cmd to an ALU operation; unknown commands are flagged illegal.
  always_comb begin
    alu_ctl  = ALU_ADD;
    legal    = 1'b1;
    no_write = 1'b0;
    case (cmd)
      CMD_ADD: alu_ctl = ALU_ADD;
      CMD_SUB: alu_ctl = ALU_SUB;
      CMD_AND: alu_ctl = ALU_AND;
      CMD_ORR: alu_ctl = ALU_ORR;
      CMD_ADC: alu_ctl = ALU_ADC;
      CMD_EOR: alu_ctl = ALU_EOR;
      CMD_RSB: alu_ctl = ALU_RSB;
      CMD_CMP: begin alu_ctl = ALU_SUB; no_write = 1'b1; end
      CMD_TST: begin alu_ctl = ALU_AND; no_write = 1'b1; end
      CMD_CMN: begin alu_ctl = ALU_ADD; no_write = 1'b1; end
      CMD_TEQ: begin alu_ctl = ALU_EOR; no_write = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  // Compare/test commands exist only for their flags, so they always update
  // flags; C/V are written only by arithmetic operations.
  always_comb begin
    s_eff     = (s_bit | no_write) & legal;
    flag_w[1] = s_eff;
    flag_w[0] = s_eff & (alu_ctl inside {ALU_ADD, ALU_SUB, ALU_ADC, ALU_RSB});
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle processor main controller (Moore FSM with mem_ready-qualified
// fetch strobes), memory wait watchdog and sticky fault state.
// Optional feature macro: MC_CTRL_COND_EN (condition evaluation in DECODE).
//
// Memory handshake: mem_req stays high for the whole access; the access
// completes on the rising edge at which mem_ready is high. mem_ready is
// ignored in every state that does not drive mem_req.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTL_W = 3,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          op,
  input  logic [5:0]          funct,
  input  logic [3:0]          rd,
  input  logic [3:0]          cond,
  input  logic [3:0]          flags,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_w,
  output logic                adr_src,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_w,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          result_src,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic [1:0]          flag_w,
  output logic                fault,
  output logic [3:0]          state_o
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [3:0] state, state_next;
  logic [7:0] wait_cnt, wait_next;
  logic       waiting, timeout_hit;
  logic       cond_ok;
  logic [2:0] dec_alu_ctl;
  logic       dec_legal, dec_no_write;
  logic [1:0] dec_flag_w;
  ctrl_t      ctrl_c, ctrl_o;

`ifdef MC_CTRL_COND_EN
  assign cond_ok = cond_pass(cond, flags);
`else
  logic unused_cond_flags;
  assign unused_cond_flags = ^{cond, flags};
  assign cond_ok = 1'b1;
`endif

  mc_alu_dec u_alu_dec (
    .cmd      (funct[4:1]),
    .s_bit    (funct[0]),
    .alu_ctl  (dec_alu_ctl),
    .legal    (dec_legal),
    .no_write (dec_no_write),
    .flag_w   (dec_flag_w)
  );

  // Watchdog: a memory-facing state is stalled this cycle; the TIMEOUT-th
  // stalled cycle faults unless mem_ready arrives in that same cycle.
  always_comb begin
    waiting     = ((state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE))
                  && !mem_ready;
    timeout_hit = waiting && (wait_cnt == WAIT_LAST);
  end

  // Next-state and Moore control outputs.
  always_comb begin
    ctrl_c     = '0;
    state_next = state;
    case (state)
      S_FETCH: begin
        ctrl_c.mem_req    = 1'b1;
        ctrl_c.alu_src_a  = 1'b1;
        ctrl_c.alu_src_b  = 2'b10;
        ctrl_c.result_src = 2'b10;
        ctrl_c.ir_write   = mem_ready;
        ctrl_c.pc_write   = mem_ready;
        if (mem_ready)        state_next = S_DECODE;
        else if (timeout_hit) state_next = S_FAULT;
      end
      S_DECODE: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = 2'b10;
        if (!cond_ok) begin
          state_next = S_FETCH;
        end else begin
          case (op)
            OP_MEM:  state_next = S_MEMADDR;
            OP_DP:   state_next = funct[5] ? S_EXEC_I : S_EXEC_R;
            OP_BR:   state_next = S_BRANCH;
            default: state_next = S_FAULT;
          endcase
        end
      end
      S_MEMADDR: begin
        ctrl_c.alu_src_b = 2'b01;
        state_next = funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_EXEC_R, S_EXEC_I: begin
        ctrl_c.alu_src_b = (state == S_EXEC_I) ? 2'b01 : 2'b00;
        if (dec_legal) begin
          ctrl_c.alu_ctl = dec_alu_ctl;
          ctrl_c.flag_w  = dec_flag_w;
          state_next = dec_no_write ? S_FETCH : S_ALUWB;
        end else begin
          state_next = S_FAULT;
        end
      end
      S_ALUWB: begin
        ctrl_c.reg_w      = 1'b1;
        ctrl_c.result_src = 2'b00;
        ctrl_c.pc_write   = (rd == 4'd15);
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_b  = 2'b01;
        ctrl_c.result_src = 2'b10;
        ctrl_c.pc_write   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMREAD: begin
        ctrl_c.mem_req = 1'b1;
        ctrl_c.adr_src = 1'b1;
        if (mem_ready)        state_next = S_MEMWB;
        else if (timeout_hit) state_next = S_FAULT;
      end
      S_MEMWRITE: begin
        ctrl_c.mem_req = 1'b1;
        ctrl_c.mem_w   = 1'b1;
        ctrl_c.adr_src = 1'b1;
        if (mem_ready)        state_next = S_FETCH;
        else if (timeout_hit) state_next = S_FAULT;
      end
      S_MEMWB: begin
        ctrl_c.reg_w      = 1'b1;
        ctrl_c.result_src = 2'b01;
        ctrl_c.pc_write   = (rd == 4'd15);
        state_next = S_FETCH;
      end
      S_FAULT: begin
        ctrl_c.fault = 1'b1;
      end
      default: begin
        state_next = S_FAULT;
      end
    endcase
  end

  // Wait counter restarts on every state change and only counts stalls.
  always_comb begin
    if (state_next != state) wait_next = '0;
    else if (waiting)        wait_next = wait_cnt + 8'd1;
    else                     wait_next = '0;
  end

  // State and watchdog registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  // All outputs are forced low the moment reset asserts.
  always_comb begin
    ctrl_o  = reset ? ctrl_c : '0;
    state_o = reset ? state : S_FETCH;
  end

  assign mem_req     = ctrl_o.mem_req;
  assign mem_w       = ctrl_o.mem_w;
  assign adr_src     = ctrl_o.adr_src;
  assign ir_write    = ctrl_o.ir_write;
  assign pc_write    = ctrl_o.pc_write;
  assign reg_w       = ctrl_o.reg_w;
  assign alu_src_a   = ctrl_o.alu_src_a;
  assign alu_src_b   = ctrl_o.alu_src_b;
  assign result_src  = ctrl_o.result_src;
  assign alu_control = ALUCTL_W'(ctrl_o.alu_ctl);
  assign flag_w      = ctrl_o.flag_w;
  assign fault       = ctrl_o.fault;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: instruction walks, watchdog boundaries,
// fault stickiness and asynchronous reset behaviour.
module tb_mc_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd, cond, flags;
  logic       mem_ready;
  logic       mem_req, mem_w, adr_src, ir_write, pc_write, reg_w, alu_src_a;
  logic [1:0] alu_src_b, result_src, flag_w;
  logic [2:0] alu_control;
  logic       fault;
  logic [3:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  mc_ctrl #(.ALUCTL_W(3), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd), .cond(cond),
    .flags(flags), .mem_ready(mem_ready), .mem_req(mem_req), .mem_w(mem_w),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_w(reg_w),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_control(alu_control), .flag_w(flag_w), .fault(fault), .state_o(state_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next falling edge; the DUT has taken one rising edge.
  task automatic step_cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply a new instruction while in FETCH with memory ready.
  task automatic issue(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r);
    op = o; funct = f; rd = r; mem_ready = 1'b1;
    #1;
  endtask

  initial begin
    reset = 1'b0; op = 2'b00; funct = 6'b0; rd = 4'd0;
    cond = 4'b1110; flags = 4'b0000; mem_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_state", state_o, 0);
    chk("rst_fault", fault, 0);
    chk("rst_alu_src_b", alu_src_b, 0);

    // ADD immediate, rd=3
    step_cyc();
    reset = 1'b1;
    issue(2'b00, 6'b101000, 4'd3);
    chk("add_fetch_state", state_o, 0);
    chk("add_fetch_mem_req", mem_req, 1);
    chk("add_fetch_ir_write", ir_write, 1);
    chk("add_fetch_pc_write", pc_write, 1);
    chk("add_fetch_src_b", alu_src_b, 2);
    step_cyc();
    chk("add_decode_state", state_o, 1);
    chk("add_decode_src_a", alu_src_a, 1);
    chk("add_decode_mem_req", mem_req, 0);
    step_cyc();
    chk("add_exec_state", state_o, 4);
    chk("add_exec_aluctl", alu_control, 0);
    chk("add_exec_src_b", alu_src_b, 1);
    chk("add_exec_flag_w", flag_w, 0);
    step_cyc();
    chk("add_wb_state", state_o, 8);
    chk("add_wb_reg_w", reg_w, 1);
    chk("add_wb_pc_write", pc_write, 0);
    step_cyc();
    chk("add_back_fetch", state_o, 0);

    // CMP register, S=1: flags only, no write-back
    issue(2'b00, 6'b010101, 4'd2);
    step_cyc();
    step_cyc();
    chk("cmp_exec_state", state_o, 3);
    chk("cmp_exec_aluctl", alu_control, 1);
    chk("cmp_exec_flag_w", flag_w, 3);
    chk("cmp_exec_src_b", alu_src_b, 0);
    step_cyc();
    chk("cmp_back_fetch", state_o, 0);
    chk("cmp_no_reg_w", reg_w, 0);

    // SUB register, S=1: flag_w=11 then ALUWB
    issue(2'b00, 6'b000101, 4'd4);
    step_cyc();
    step_cyc();
    chk("sub_exec_aluctl", alu_control, 1);
    chk("sub_exec_flag_w", flag_w, 3);
    step_cyc();
    chk("sub_wb_state", state_o, 8);
    step_cyc();

    // ORR immediate, S=1: logical op writes only NZ
    issue(2'b00, 6'b111001, 4'd5);
    step_cyc();
    step_cyc();
    chk("orr_exec_aluctl", alu_control, 3);
    chk("orr_exec_flag_w", flag_w, 2);
    step_cyc();
    step_cyc();

    // LDR to r15 with 3 stall cycles in MEMREAD
    issue(2'b01, 6'b000001, 4'd15);
    step_cyc();
    mem_ready = 1'b0;
    #1;
    chk("ldr_decode_state", state_o, 1);
    step_cyc();
    chk("ldr_memaddr_state", state_o, 2);
    chk("ldr_memaddr_src_b", alu_src_b, 1);
    step_cyc();
    chk("ldr_memread_state", state_o, 6);
    chk("ldr_memread_adr_src", adr_src, 1);
    chk("ldr_memread_mem_w", mem_w, 0);
    step_cyc();
    step_cyc();
    chk("ldr_stall_state", state_o, 6);
    step_cyc();
    mem_ready = 1'b1;
    #1;
    chk("ldr_stall3_state", state_o, 6);
    step_cyc();
    chk("ldr_memwb_state", state_o, 9);
    chk("ldr_memwb_reg_w", reg_w, 1);
    chk("ldr_memwb_pc_write", pc_write, 1);
    chk("ldr_memwb_result", result_src, 1);
    step_cyc();
    chk("ldr_back_fetch", state_o, 0);

    // STR, memory ready immediately
    issue(2'b01, 6'b000000, 4'd1);
    step_cyc();
    step_cyc();
    step_cyc();
    chk("str_memwrite_state", state_o, 7);
    chk("str_memwrite_mem_w", mem_w, 1);
    chk("str_memwrite_mem_req", mem_req, 1);
    step_cyc();
    chk("str_back_fetch", state_o, 0);

    // Branch
    issue(2'b10, 6'b000000, 4'd0);
    step_cyc();
    step_cyc();
    chk("br_state", state_o, 5);
    chk("br_pc_write", pc_write, 1);
    chk("br_src_a", alu_src_a, 0);
    chk("br_result", result_src, 2);
    step_cyc();

    // EQ condition with Z=0
    cond = 4'b0000;
    flags = 4'b0000;
    issue(2'b00, 6'b101000, 4'd6);
    step_cyc();
    step_cyc();
`ifdef MC_CTRL_COND_EN
    chk("cond_fail_state", state_o, 0);
    chk("cond_fail_reg_w", reg_w, 0);
`else
    chk("cond_ignored_state", state_o, 4);
    step_cyc();
    chk("cond_ignored_reg_w", reg_w, 1);
    step_cyc();
`endif
    cond = 4'b1110;

    // Illegal cmd -> sticky FAULT
    issue(2'b00, 6'b001110, 4'd0);
    step_cyc();
    step_cyc();
    chk("illegal_exec_state", state_o, 3);
    step_cyc();
    chk("illegal_fault_state", state_o, 10);
    chk("illegal_fault", fault, 1);
    chk("illegal_fault_mem_req", mem_req, 0);
    repeat (3) step_cyc();
    chk("fault_sticky", fault, 1);
    reset = 1'b0;
    #1;
    chk("fault_clr_async", fault, 0);
    chk("fault_clr_state", state_o, 0);
    step_cyc();
    reset = 1'b1;

    // op=11 -> FAULT
    issue(2'b11, 6'b000000, 4'd0);
    step_cyc();
    step_cyc();
    chk("undef_op_fault", fault, 1);
    reset = 1'b0;
    step_cyc();
    reset = 1'b1;

    // Reset during MEMWRITE
    issue(2'b01, 6'b000000, 4'd0);
    step_cyc();
    mem_ready = 1'b0;
    step_cyc();
    step_cyc();
    #1;
    chk("rstw_memwrite_req", mem_req, 1);
    reset = 1'b0;
    #1;
    chk("rstw_req_drop", mem_req, 0);
    step_cyc();
    reset = 1'b1;
    #1;
    chk("rstw_release_state", state_o, 0);
    chk("rstw_release_req", mem_req, 1);

    // Timeout in FETCH: mem_ready arrives in the 15th stall cycle and wins
    op = 2'b10;
    repeat (14) step_cyc();
    mem_ready = 1'b1;
    #1;
    chk("to_win_pre_state", state_o, 0);
    step_cyc();
    chk("to_win_decode", state_o, 1);
    chk("to_win_fault", fault, 0);
    step_cyc();
    step_cyc();

    // Timeout in FETCH: 15 stall cycles -> FAULT
    mem_ready = 1'b0;
    #1;
    repeat (14) step_cyc();
    chk("to_cycle15_state", state_o, 0);
    step_cyc();
    chk("to_fault_state", state_o, 10);
    chk("to_fault", fault, 1);
    mem_ready = 1'b1;
    repeat (2) step_cyc();
    chk("to_fault_sticky", fault, 1);
    reset = 1'b0;
    #1;
    chk("to_reset_clears", fault, 0);
    step_cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
